// File: rtl/vga_plot_arbiter_pkg.sv
// Shared screen geometry, arbiter state encodings and owner encoding for the VGA plot path.
package vga_plot_arbiter_pkg;

  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 120;
  localparam int XW_DEF    = 8;
  localparam int YW_DEF    = 7;
  localparam int CW_DEF    = 3;

  typedef enum logic [1:0] {
    ARB         = 2'd0,
    HOLD_GAME   = 2'd1,
    HOLD_SPLASH = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_GAME   = 1'b0,
    OWN_SPLASH = 1'b1
  } owner_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_out_stage.sv
// One-entry registered pixel stage toward the VGA adapter, with off-screen clipping.
// Clipped beats are consumed and only counted (saturating at 255).
module plot_out_stage
  import vga_plot_arbiter_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic [CW-1:0] in_colour,
  output logic          in_ready,
  output logic          out_plot,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] out_colour,
  input  logic          out_ready,
  output logic [7:0]    clip_count
);

  localparam logic [XW:0] X_LIM = (XW + 1)'(X_MAX);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(Y_MAX);

  logic take;
  logic in_range;

  assign in_ready = !out_plot || out_ready;
  assign take     = in_valid && in_ready;
  assign in_range = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_plot   <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      clip_count <= 8'd0;
    end else if (take) begin
      // A clipped beat leaves the stage empty: it was free, so any old pixel drains now.
      if (in_range) begin
        out_plot   <= 1'b1;
        out_x      <= in_x;
        out_y      <= in_y;
        out_colour <= in_colour;
      end else begin
        out_plot   <= 1'b0;
        clip_count <= sat_inc8(clip_count);
      end
    end else if (out_ready) begin
      out_plot <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter with burst locking sharing the VGA pixel-write port between game and splash.
// Grants are combinational from registered state; the pixel reaches the adapter one cycle after acceptance.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          game_valid,
  input  logic          game_lock,
  input  logic [XW-1:0] game_x,
  input  logic [YW-1:0] game_y,
  input  logic [CW-1:0] game_colour,
  output logic          game_ready,
  input  logic          spl_valid,
  input  logic          spl_lock,
  input  logic [XW-1:0] spl_x,
  input  logic [YW-1:0] spl_y,
  input  logic [CW-1:0] spl_colour,
  output logic          spl_ready,
  output logic          out_plot,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] out_colour,
  input  logic          out_ready,
  output logic [7:0]    clip_count,
  output logic          owner
);

  arb_state_t state_q, state_d;
  owner_t     rr_last_q, rr_last_d;
  owner_t     owner_q, grant;
  logic       grant_vld;
  logic       stage_free;
  logic       beat_vld;
  logic [XW-1:0] beat_x;
  logic [YW-1:0] beat_y;
  logic [CW-1:0] beat_colour;

  always_comb begin
    grant_vld   = 1'b0;
    grant       = owner_q;
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    game_ready  = 1'b0;
    spl_ready   = 1'b0;
    beat_vld    = 1'b0;
    beat_x      = game_x;
    beat_y      = game_y;
    beat_colour = game_colour;

    unique case (state_q)
      ARB: begin
        if (game_valid && spl_valid) begin
          grant_vld = 1'b1;
          grant     = (rr_last_q == OWN_SPLASH) ? OWN_GAME : OWN_SPLASH;
        end else if (game_valid) begin
          grant_vld = 1'b1;
          grant     = OWN_GAME;
        end else if (spl_valid) begin
          grant_vld = 1'b1;
          grant     = OWN_SPLASH;
        end
      end
      HOLD_GAME: begin
        grant_vld = 1'b1;
        grant     = OWN_GAME;
      end
      HOLD_SPLASH: begin
        grant_vld = 1'b1;
        grant     = OWN_SPLASH;
      end
      default: ;
    endcase

    // Keep handshakes quiet while reset is asserted, whatever the requesters drive.
    if (!reset_n) begin
      grant_vld = 1'b0;
      grant     = owner_q;
    end

    game_ready = grant_vld && (grant == OWN_GAME)   && game_valid && stage_free;
    spl_ready  = grant_vld && (grant == OWN_SPLASH) && spl_valid  && stage_free;
    beat_vld   = game_ready || spl_ready;

    if (spl_ready) begin
      beat_x      = spl_x;
      beat_y      = spl_y;
      beat_colour = spl_colour;
    end

    if (beat_vld) rr_last_d = grant;

    unique case (state_q)
      ARB: begin
        if (game_ready && game_lock)     state_d = HOLD_GAME;
        else if (spl_ready && spl_lock)  state_d = HOLD_SPLASH;
      end
      HOLD_GAME:   if (!game_lock) state_d = ARB;
      HOLD_SPLASH: if (!spl_lock)  state_d = ARB;
      default:     state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB;
      rr_last_q <= OWN_SPLASH;
      owner_q   <= OWN_GAME;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= grant;
    end
  end

  assign owner = grant;

  plot_out_stage #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .XW(XW), .YW(YW), .CW(CW)
  ) u_stage (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (beat_vld),
    .in_x       (beat_x),
    .in_y       (beat_y),
    .in_colour  (beat_colour),
    .in_ready   (stage_free),
    .out_plot   (out_plot),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .out_ready  (out_ready),
    .clip_count (clip_count)
  );

endmodule
